// File: rtl/vector_mult_pkg.sv
// Shared types, default sizes and width helper for the vector pair dot product block.
package vector_mult_pkg;

  typedef enum logic [1:0] {
    IDLE_A,
    WAIT_B,
    MAC,
    WRITE
  } dp_state_t;

  localparam int DEFAULT_ELEMENT_WIDTH    = 24;
  localparam int DEFAULT_ADDR_WIDTH       = 17;
  localparam int DEFAULT_VECTOR_DIMENSION = 3;

  // Width that holds a sum of n products of ew-bit signed values without overflow.
  function automatic int result_width(input int ew, input int n);
    return 2 * ew + $clog2(n);
  endfunction

endpackage

// File: rtl/signed_mac.sv
// Single signed multiplier feeding a sign-extended accumulator.
module signed_mac #(
  parameter int ELEMENT_WIDTH = 24,
  parameter int RESULT_WIDTH  = 50
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [ELEMENT_WIDTH-1:0] a,
  input  logic [ELEMENT_WIDTH-1:0] b,
  output logic [RESULT_WIDTH-1:0]  acc
);

  localparam int PW = 2 * ELEMENT_WIDTH;

  logic signed [PW-1:0]    product;
  logic [RESULT_WIDTH-1:0] acc_q;

  assign product = $signed(a) * $signed(b);

  // acc already includes the current product, so the caller can capture the final sum
  // on the same edge that retires the last element.
  assign acc = acc_q + {{(RESULT_WIDTH - PW){product[PW-1]}}, product};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_q <= '0;
    end else if (enable) begin
      acc_q <= acc;
    end
  end

endmodule

// File: rtl/vector_pair_dot_product.sv
// Pairs consecutive vectors as (A, B), computes their signed dot product and writes it out.
//
//   state  | meaning
//   IDLE_A | waiting for the A vector of the next pair
//   WAIT_B | A held, waiting for the B vector
//   MAC    | one element product accumulated per cycle
//   WRITE  | result_we high; pick up next A from pend buffer or input
module vector_pair_dot_product
  import vector_mult_pkg::*;
#(
  parameter int  ELEMENT_WIDTH    = DEFAULT_ELEMENT_WIDTH,
  parameter int  ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
  parameter int  VECTOR_DIMENSION = DEFAULT_VECTOR_DIMENSION,
  localparam int RESULT_WIDTH     = result_width(ELEMENT_WIDTH, VECTOR_DIMENSION)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ELEMENT_WIDTH-1:0] vector_in [0:VECTOR_DIMENSION-1],
  input  logic                     vector_valid,
  input  logic [ADDR_WIDTH-1:0]    expected_pairs,
  output logic [RESULT_WIDTH-1:0]  result_data,
  output logic [ADDR_WIDTH-1:0]    result_addr,
  output logic                     result_we,
  output logic [ADDR_WIDTH-1:0]    pairs_completed,
  output logic                     busy,
  output logic                     overrun,
  output logic                     done
);

  localparam int IDX_W = $clog2(VECTOR_DIMENSION);

  dp_state_t state, state_next;

  logic [ELEMENT_WIDTH-1:0] a_reg    [0:VECTOR_DIMENSION-1];
  logic [ELEMENT_WIDTH-1:0] b_reg    [0:VECTOR_DIMENSION-1];
  logic [ELEMENT_WIDTH-1:0] pend_reg [0:VECTOR_DIMENSION-1];
  logic                     pend_valid;
  logic [IDX_W-1:0]         idx;
  logic                     idx_last;
  logic                     vin_ok;
  logic                     mac_clear;
  logic                     mac_enable;
  logic [RESULT_WIDTH-1:0]  mac_acc;

  assign done     = (pairs_completed == expected_pairs);
  assign busy     = (state != IDLE_A);
  // Input is frozen once the requested number of pairs has been written.
  assign vin_ok   = vector_valid && !done;
  assign idx_last = (idx == IDX_W'(VECTOR_DIMENSION - 1));

  assign mac_clear  = (state == WAIT_B) && vin_ok;
  assign mac_enable = (state == MAC);

  signed_mac #(
    .ELEMENT_WIDTH (ELEMENT_WIDTH),
    .RESULT_WIDTH  (RESULT_WIDTH)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (mac_clear),
    .enable (mac_enable),
    .a      (a_reg[idx]),
    .b      (b_reg[idx]),
    .acc    (mac_acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE_A;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE_A: if (vin_ok) state_next = WAIT_B;
      WAIT_B: if (vin_ok) state_next = MAC;
      MAC:    if (idx_last) state_next = WRITE;
      WRITE:  state_next = (pend_valid || vin_ok) ? WAIT_B : IDLE_A;
      default: state_next = IDLE_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_data     <= '0;
      result_addr     <= '0;
      result_we       <= 1'b0;
      pairs_completed <= '0;
      overrun         <= 1'b0;
      pend_valid      <= 1'b0;
      idx             <= '0;
    end else begin
      result_we <= 1'b0;
      unique case (state)
        IDLE_A: if (vin_ok) a_reg <= vector_in;
        WAIT_B: begin
          if (vin_ok) begin
            b_reg <= vector_in;
            idx   <= '0;
          end
        end
        MAC: begin
          idx <= idx + 1'b1;
          if (idx_last) begin
            result_data <= mac_acc;
            result_addr <= pairs_completed;
            result_we   <= 1'b1;
          end
          if (vin_ok) begin
            if (pend_valid) begin
              overrun <= 1'b1;
            end else begin
              pend_reg   <= vector_in;
              pend_valid <= 1'b1;
            end
          end
        end
        WRITE: begin
          pairs_completed <= pairs_completed + 1'b1;
          // A buffered vector is older than one arriving now, so it becomes A first.
          if (pend_valid) begin
            a_reg      <= pend_reg;
            pend_valid <= 1'b0;
            if (vin_ok) overrun <= 1'b1;
          end else if (vin_ok) begin
            a_reg <= vector_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_pair_dot_product.sv
// Randomized self-checking bench for vector_pair_dot_product against a plain-arithmetic pair model.
module tb_vector_pair_dot_product;

  localparam int EW = 24;
  localparam int AW = 17;
  localparam int N  = 3;
  localparam int RW = 2 * EW + $clog2(N);

  typedef int vec_t [N];

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [EW-1:0] vector_in [0:N-1];
  logic          vector_valid = 1'b0;
  logic [AW-1:0] expected_pairs = '0;
  logic [RW-1:0] result_data;
  logic [AW-1:0] result_addr;
  logic          result_we;
  logic [AW-1:0] pairs_completed;
  logic          busy;
  logic          overrun;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  logic [RW-1:0] got_data [$];
  logic [AW-1:0] got_addr [$];

  vector_pair_dot_product #(
    .ELEMENT_WIDTH    (EW),
    .ADDR_WIDTH       (AW),
    .VECTOR_DIMENSION (N)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .vector_in       (vector_in),
    .vector_valid    (vector_valid),
    .expected_pairs  (expected_pairs),
    .result_data     (result_data),
    .result_addr     (result_addr),
    .result_we       (result_we),
    .pairs_completed (pairs_completed),
    .busy            (busy),
    .overrun         (overrun),
    .done            (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && result_we === 1'b1) begin
      got_data.push_back(result_data);
      got_addr.push_back(result_addr);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [RW-1:0] ref_dot(input vec_t a, input vec_t b);
    longint s;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(a[i]) * longint'(b[i]);
    return RW'(s);
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, (1 << EW) - 1)) - (1 << (EW - 1));
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input vec_t v);
    for (int i = 0; i < N; i++) vector_in[i] = EW'(v[i]);
    vector_valid = 1'b1;
    @(posedge clk);
    #1;
    vector_valid = 1'b0;
  endtask

  task automatic do_reset(input logic [AW-1:0] ep);
    expected_pairs = ep;
    vector_valid   = 1'b0;
    reset          = 1'b1;
    step(2);
    reset = 1'b0;
    got_data.delete();
    got_addr.delete();
  endtask

  task automatic wait_we(output int cyc);
    cyc = 0;
    while (result_we !== 1'b1 && cyc < 20) begin
      step(1);
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset(AW'(100));
    n_cmp++; if (result_data !== '0) begin n_err++; $display("FAIL reset_data: got %0h want 0", result_data); end
    n_cmp++; if (result_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %0h want 0", result_addr); end
    n_cmp++; if (result_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", result_we); end
    n_cmp++; if (pairs_completed !== '0) begin n_err++; $display("FAIL reset_pairs: got %0d want 0", pairs_completed); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_done_zero();
    do_reset('0);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b want 1", done); end
    send(rand_vec());
    step(3);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_ignored_busy: got %b want 0", busy); end
    n_cmp++; if (got_data.size() != 0) begin n_err++; $display("FAIL zero_no_write: got %0d writes want 0", got_data.size()); end
  endtask

  task automatic test_basic();
    vec_t a = '{1, 2, 3};
    vec_t b = '{4, 5, 6};
    int cyc;
    do_reset(AW'(100));
    send(a);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_a: got %b want 1", busy); end
    send(b);
    wait_we(cyc);
    n_cmp++; if (cyc != N) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", cyc, N); end
    n_cmp++; if (result_data !== ref_dot(a, b)) begin n_err++; $display("FAIL basic_data: got %0d want %0d", result_data, ref_dot(a, b)); end
    n_cmp++; if (result_addr !== '0) begin n_err++; $display("FAIL basic_addr: got %0d want 0", result_addr); end
    step(1);
    n_cmp++; if (result_we !== 1'b0) begin n_err++; $display("FAIL basic_we_width: got %b want 0", result_we); end
    n_cmp++; if (pairs_completed !== AW'(1)) begin n_err++; $display("FAIL basic_pairs: got %0d want 1", pairs_completed); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: got %b want 0", busy); end
  endtask

  task automatic test_signed();
    vec_t a = '{-1, 2, -3};
    vec_t b = '{4, -5, 6};
    int cyc;
    do_reset(AW'(100));
    send(a);
    send(b);
    wait_we(cyc);
    n_cmp++; if (cyc != N) begin n_err++; $display("FAIL signed_latency: got %0d want %0d", cyc, N); end
    n_cmp++; if (result_data !== ref_dot(a, b)) begin n_err++; $display("FAIL signed_data: got %0h want %0h", result_data, ref_dot(a, b)); end
  endtask

  task automatic test_extremes();
    vec_t a = '{-(1 << (EW - 1)), -(1 << (EW - 1)), -(1 << (EW - 1))};
    int cyc;
    do_reset(AW'(100));
    send(a);
    send(a);
    wait_we(cyc);
    n_cmp++; if (cyc != N) begin n_err++; $display("FAIL extreme_latency: got %0d want %0d", cyc, N); end
    n_cmp++; if (result_data !== ref_dot(a, a)) begin n_err++; $display("FAIL extreme_data: got %0h want %0h", result_data, ref_dot(a, a)); end
  endtask

  task automatic test_cadence();
    vec_t v [8];
    do_reset(AW'(4));
    for (int k = 0; k < 8; k++) begin
      v[k] = rand_vec();
      send(v[k]);
      if (k == 7) begin
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL cadence_not_done: got %b want 0", done); end
      end
      step(2);
    end
    step(8);
    n_cmp++; if (got_data.size() != 4) begin n_err++; $display("FAIL cadence_count: got %0d want 4", got_data.size()); end
    for (int p = 0; p < 4 && p < got_data.size(); p++) begin
      n_cmp++; if (got_data[p] !== ref_dot(v[2*p], v[2*p+1])) begin n_err++; $display("FAIL cadence_data[%0d]: got %0h want %0h", p, got_data[p], ref_dot(v[2*p], v[2*p+1])); end
      n_cmp++; if (got_addr[p] !== AW'(p)) begin n_err++; $display("FAIL cadence_addr[%0d]: got %0d want %0d", p, got_addr[p], p); end
    end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL cadence_overrun: got %b want 0", overrun); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL cadence_done: got %b want 1", done); end
    send(rand_vec());
    step(8);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cadence_ignore_busy: got %b want 0", busy); end
    n_cmp++; if (pairs_completed !== AW'(4)) begin n_err++; $display("FAIL cadence_ignore_pairs: got %0d want 4", pairs_completed); end
    n_cmp++; if (got_data.size() != 4) begin n_err++; $display("FAIL cadence_ignore_writes: got %0d want 4", got_data.size()); end
  endtask

  task automatic test_random();
    vec_t v [$];
    vec_t x;
    int   k = 12;
    do_reset(AW'(1000));
    for (int i = 0; i < 2 * k; i++) begin
      x = rand_vec();
      v.push_back(x);
      send(x);
      step(int'($urandom_range(2, 5)));
    end
    step(10);
    n_cmp++; if (got_data.size() != k) begin n_err++; $display("FAIL random_count: got %0d want %0d", got_data.size(), k); end
    for (int p = 0; p < k && p < got_data.size(); p++) begin
      n_cmp++; if (got_data[p] !== ref_dot(v[2*p], v[2*p+1])) begin n_err++; $display("FAIL random_data[%0d]: got %0h want %0h", p, got_data[p], ref_dot(v[2*p], v[2*p+1])); end
      n_cmp++; if (got_addr[p] !== AW'(p)) begin n_err++; $display("FAIL random_addr[%0d]: got %0d want %0d", p, got_addr[p], p); end
    end
    n_cmp++; if (pairs_completed !== AW'(k)) begin n_err++; $display("FAIL random_pairs: got %0d want %0d", pairs_completed, k); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL random_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_overrun();
    vec_t a0 = rand_vec();
    vec_t b0 = rand_vec();
    vec_t p  = rand_vec();
    vec_t d  = rand_vec();
    vec_t q  = rand_vec();
    do_reset(AW'(100));
    send(a0);
    send(b0);
    send(p);
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_pend_only: got %b want 0", overrun); end
    send(d);
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b want 1", overrun); end
    step(3);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL overrun_pend_as_a: got busy %b want 1", busy); end
    send(q);
    step(8);
    n_cmp++; if (got_data.size() != 2) begin n_err++; $display("FAIL overrun_count: got %0d want 2", got_data.size()); end
    if (got_data.size() >= 2) begin
      n_cmp++; if (got_data[0] !== ref_dot(a0, b0)) begin n_err++; $display("FAIL overrun_data0: got %0h want %0h", got_data[0], ref_dot(a0, b0)); end
      n_cmp++; if (got_data[1] !== ref_dot(p, q)) begin n_err++; $display("FAIL overrun_data1: got %0h want %0h", got_data[1], ref_dot(p, q)); end
      n_cmp++; if (got_addr[1] !== AW'(1)) begin n_err++; $display("FAIL overrun_addr1: got %0d want 1", got_addr[1]); end
    end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    n_cmp++; if (pairs_completed !== AW'(2)) begin n_err++; $display("FAIL overrun_pairs: got %0d want 2", pairs_completed); end
  endtask

  task automatic test_reset_mid();
    vec_t a  = rand_vec();
    vec_t b  = rand_vec();
    vec_t a2 = rand_vec();
    vec_t b2 = rand_vec();
    int   cyc;
    do_reset(AW'(100));
    send(a);
    send(b);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_cmp++; if (result_we !== 1'b0) begin n_err++; $display("FAIL midrst_we: got %b want 0", result_we); end
    n_cmp++; if (result_data !== '0) begin n_err++; $display("FAIL midrst_data: got %0h want 0", result_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (pairs_completed !== '0) begin n_err++; $display("FAIL midrst_pairs: got %0d want 0", pairs_completed); end
    step(6);
    n_cmp++; if (got_data.size() != 0) begin n_err++; $display("FAIL midrst_no_write: got %0d writes want 0", got_data.size()); end
    send(a2);
    send(b2);
    wait_we(cyc);
    n_cmp++; if (cyc != N) begin n_err++; $display("FAIL midrst_latency: got %0d want %0d", cyc, N); end
    n_cmp++; if (result_addr !== '0) begin n_err++; $display("FAIL midrst_addr: got %0d want 0", result_addr); end
    n_cmp++; if (result_data !== ref_dot(a2, b2)) begin n_err++; $display("FAIL midrst_data2: got %0h want %0h", result_data, ref_dot(a2, b2)); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) vector_in[i] = '0;
    test_reset();
    test_done_zero();
    test_basic();
    test_signed();
    test_extremes();
    test_cadence();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
